// File: rtl/dual_port_ram.sv
// True dual-port RAM: two independent read/write ports on one clock, registered reads.
// Register-based storage so that the asynchronous reset can clear every word at once.
module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      hit_a;
    logic [DEPTH-1:0]      hit_b;
    logic                  collide;

    // One-hot word selects for each port's write.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
        assign hit_a[gi] = we_a && (addr_a == ADDR_WIDTH'(gi));
        assign hit_b[gi] = we_b && (addr_b == ADDR_WIDTH'(gi));
    end

    assign collide = we_a && we_b && (addr_a == addr_b);

    // Port A has priority when both ports write the same word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit_a[i]) begin
                    mem[i] <= din_a;
                end else if (hit_b[i]) begin
                    mem[i] <= din_b;
                end
            end
        end
    end

    // Write-first on the own port; a write from the other port is seen only next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_a <= '0;
        end else if (we_a) begin
            dout_a <= din_a;
        end else begin
            dout_a <= mem[addr_a];
        end
    end

    // On a collision port B reports the value actually stored, i.e. port A's data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_b <= '0;
        end else if (collide) begin
            dout_b <= din_a;
        end else if (we_b) begin
            dout_b <= din_b;
        end else begin
            dout_b <= mem[addr_b];
        end
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: directed scenarios followed by random traffic against a word-array model.
module tb_dual_port_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic       we_a, we_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] din_a, din_b;
    logic [7:0] dout_a, dout_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [16];
    logic [7:0] exp_a, exp_b;

    always #5 clk = ~clk;

    dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
        .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b)
    );

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        exp_a = 8'h00;
        exp_b = 8'h00;
    endtask

    // Drive one transaction from a falling edge, let one rising edge pass, return on the next falling edge.
    task automatic cycle(input logic wa, input logic [3:0] aa, input logic [7:0] da,
                         input logic wb, input logic [3:0] ab, input logic [7:0] db);
        we_a = wa; addr_a = aa; din_a = da;
        we_b = wb; addr_b = ab; din_b = db;
        @(posedge clk);
        // Reads see pre-edge contents; own-port writes are returned directly; on a same-word double write A's data is what lands.
        if (wa) exp_a = da; else exp_a = ref_mem[aa];
        if (wb) exp_b = (wa && aa == ab) ? da : db; else exp_b = ref_mem[ab];
        if (wb) ref_mem[ab] = db;
        if (wa) ref_mem[aa] = da;
        @(negedge clk);
        $display("txn t=%0t A(we=%0b a=%0d d=%h)->%h B(we=%0b a=%0d d=%h)->%h",
                 $time, wa, aa, da, dout_a, wb, ab, db, dout_b);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        we_a = 0; addr_a = 0; din_a = 0; we_b = 0; addr_b = 0; din_b = 0;
        repeat (2) @(negedge clk);
        model_reset();
        n_checks++; if (dout_a !== 8'h00) begin n_fail++; $display("FAIL reset_dout_a: got %h want 00", dout_a); end
        n_checks++; if (dout_b !== 8'h00) begin n_fail++; $display("FAIL reset_dout_b: got %h want 00", dout_b); end
        rst = 1'b0;
        cycle(1, 4'd5, 8'h3C, 1, 4'd7, 8'hC3);
        n_checks++; if (dout_a !== 8'h3C) begin n_fail++; $display("FAIL pre_async_a: got %h want 3c", dout_a); end
        // Assert reset between edges; outputs must clear without a clock edge.
        #2 rst = 1'b1;
        #1;
        n_checks++; if (dout_a !== 8'h00) begin n_fail++; $display("FAIL async_reset_a: got %h want 00", dout_a); end
        n_checks++; if (dout_b !== 8'h00) begin n_fail++; $display("FAIL async_reset_b: got %h want 00", dout_b); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle(0, 4'(i), 8'h00, 0, 4'(15 - i), 8'h00);
            n_checks++; if (dout_a !== 8'h00) begin n_fail++; $display("FAIL reset_sweep_a[%0d]: got %h want 00", i, dout_a); end
            n_checks++; if (dout_b !== 8'h00) begin n_fail++; $display("FAIL reset_sweep_b[%0d]: got %h want 00", 15 - i, dout_b); end
        end
    endtask

    task automatic test_port_a();
        cycle(1, 4'd4, 8'hAA, 0, 4'd0, 8'h00);
        n_checks++; if (dout_a !== 8'hAA) begin n_fail++; $display("FAIL a_write_first: got %h want aa", dout_a); end
        cycle(0, 4'd4, 8'h00, 0, 4'd0, 8'h00);
        n_checks++; if (dout_a !== 8'hAA) begin n_fail++; $display("FAIL a_readback: got %h want aa", dout_a); end
        n_checks++; if (dout_b !== 8'h00) begin n_fail++; $display("FAIL a_b_addr0: got %h want 00", dout_b); end
    endtask

    task automatic test_port_b();
        cycle(0, 4'd0, 8'h00, 1, 4'd6, 8'hBB);
        n_checks++; if (dout_b !== 8'hBB) begin n_fail++; $display("FAIL b_write_first: got %h want bb", dout_b); end
        cycle(0, 4'd0, 8'h00, 0, 4'd6, 8'h00);
        n_checks++; if (dout_b !== 8'hBB) begin n_fail++; $display("FAIL b_readback: got %h want bb", dout_b); end
        cycle(0, 4'd0, 8'h00, 0, 4'd0, 8'h00);
        n_checks++; if (dout_b !== 8'h00) begin n_fail++; $display("FAIL b_addr0: got %h want 00", dout_b); end
    endtask

    task automatic test_cross_visibility();
        cycle(0, 4'd6, 8'h00, 0, 4'd4, 8'h00);
        n_checks++; if (dout_a !== 8'hBB) begin n_fail++; $display("FAIL cross_a_reads_6: got %h want bb", dout_a); end
        n_checks++; if (dout_b !== 8'hAA) begin n_fail++; $display("FAIL cross_b_reads_4: got %h want aa", dout_b); end
        cycle(0, 4'd4, 8'h00, 0, 4'd6, 8'h00);
        n_checks++; if (dout_a !== 8'hAA) begin n_fail++; $display("FAIL cross_a_reads_4: got %h want aa", dout_a); end
        n_checks++; if (dout_b !== 8'hBB) begin n_fail++; $display("FAIL cross_b_reads_6: got %h want bb", dout_b); end
    endtask

    task automatic test_cross_rdw();
        cycle(1, 4'd2, 8'h11, 0, 4'd0, 8'h00);
        cycle(1, 4'd2, 8'h22, 0, 4'd2, 8'h00);
        n_checks++; if (dout_b !== 8'h11) begin n_fail++; $display("FAIL rdw_b_old: got %h want 11", dout_b); end
        n_checks++; if (dout_a !== 8'h22) begin n_fail++; $display("FAIL rdw_a_new: got %h want 22", dout_a); end
        cycle(0, 4'd2, 8'h00, 0, 4'd2, 8'h00);
        n_checks++; if (dout_b !== 8'h22) begin n_fail++; $display("FAIL rdw_b_next: got %h want 22", dout_b); end
        // Same check with the roles swapped: B writes, A reads.
        cycle(0, 4'd2, 8'h00, 1, 4'd2, 8'h33);
        n_checks++; if (dout_a !== 8'h22) begin n_fail++; $display("FAIL rdw_a_old: got %h want 22", dout_a); end
        n_checks++; if (dout_b !== 8'h33) begin n_fail++; $display("FAIL rdw_b_new: got %h want 33", dout_b); end
    endtask

    task automatic test_collision();
        cycle(1, 4'd9, 8'h5A, 1, 4'd9, 8'hA5);
        n_checks++; if (dout_a !== 8'h5A) begin n_fail++; $display("FAIL coll_a: got %h want 5a", dout_a); end
        n_checks++; if (dout_b !== 8'h5A) begin n_fail++; $display("FAIL coll_b: got %h want 5a", dout_b); end
        cycle(0, 4'd9, 8'h00, 0, 4'd9, 8'h00);
        n_checks++; if (dout_a !== 8'h5A) begin n_fail++; $display("FAIL coll_mem_a: got %h want 5a", dout_a); end
        n_checks++; if (dout_b !== 8'h5A) begin n_fail++; $display("FAIL coll_mem_b: got %h want 5a", dout_b); end
        // Independent writes to different words in the same edge.
        cycle(1, 4'd10, 8'h01, 1, 4'd11, 8'h02);
        cycle(0, 4'd11, 8'h00, 0, 4'd10, 8'h00);
        n_checks++; if (dout_a !== 8'h02) begin n_fail++; $display("FAIL dual_write_11: got %h want 02", dout_a); end
        n_checks++; if (dout_b !== 8'h01) begin n_fail++; $display("FAIL dual_write_10: got %h want 01", dout_b); end
    endtask

    task automatic test_midop_reset();
        cycle(1, 4'd3, 8'h77, 0, 4'd3, 8'h00);
        n_checks++; if (dout_a !== 8'h77) begin n_fail++; $display("FAIL midop_pre: got %h want 77", dout_a); end
        we_a = 1; addr_a = 4'd3; din_a = 8'h99;
        we_b = 1; addr_b = 4'd12; din_b = 8'h66;
        rst = 1'b1;
        #1;
        n_checks++; if (dout_a !== 8'h00) begin n_fail++; $display("FAIL midop_async_a: got %h want 00", dout_a); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 4'd3, 8'h00, 0, 4'd12, 8'h00);
        n_checks++; if (dout_a !== 8'h00) begin n_fail++; $display("FAIL midop_mem3: got %h want 00", dout_a); end
        n_checks++; if (dout_b !== 8'h00) begin n_fail++; $display("FAIL midop_mem12: got %h want 00", dout_b); end
        cycle(0, 4'd9, 8'h00, 0, 4'd2, 8'h00);
        n_checks++; if (dout_a !== 8'h00) begin n_fail++; $display("FAIL midop_mem9: got %h want 00", dout_a); end
        n_checks++; if (dout_b !== 8'h00) begin n_fail++; $display("FAIL midop_mem2: got %h want 00", dout_b); end
    endtask

    task automatic test_random();
        logic       wa, wb;
        logic [3:0] aa, ab;
        logic [7:0] da, db;
        for (int n = 0; n < 300; n++) begin
            wa = 1'($urandom_range(0, 1));
            wb = 1'($urandom_range(0, 1));
            aa = 4'($urandom_range(0, 15));
            // Bias toward shared addresses to exercise collisions and cross-port reads.
            ab = ($urandom_range(0, 2) == 0) ? aa : 4'($urandom_range(0, 15));
            da = 8'($urandom);
            db = 8'($urandom);
            cycle(wa, aa, da, wb, ab, db);
            n_checks++; if (dout_a !== exp_a) begin n_fail++; $display("FAIL rand_a[%0d]: got %h want %h", n, dout_a, exp_a); end
            n_checks++; if (dout_b !== exp_b) begin n_fail++; $display("FAIL rand_b[%0d]: got %h want %h", n, dout_b, exp_b); end
        end
    endtask

    initial begin
        test_reset();
        test_port_a();
        test_port_b();
        test_cross_visibility();
        test_cross_rdw();
        test_collision();
        test_midop_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
